simd_alu_pipe: RTL and testbench

- Pipelined packed-SIMD integer ALU with valid/ready handshakes on both sides.
- Generalises the split-carry packed adder to any XLEN, and adds the following:
  - signed and unsigned saturating add/sub,
  - per-lane compare masks,
  - per-lane min/max,
  - a sticky saturation flag.
- Sits beside the scalar ALU in the execute stage. It serves packed ops issued by the decoder and returns results with an opaque tag for writeback.

---
 rtl/simd_alu_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_simd_alu_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: two-stage packed-SIMD integer ALU.
// Byte/half/word lanes, saturating add/sub, compares, min/max.
module simd_alu_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [1:0]       in_pack,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_sat,
  output logic             sat_sticky,
  input  logic             sat_clr
);

  localparam int NB = XLEN / 8;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SADD, OP_SSUB,
    OP_UADD, OP_USUB, OP_AND, OP_OR,
    OP_XOR, OP_SLT, OP_SLTU, OP_SEQ,
    OP_MIN, OP_MAX, OP_MINU, OP_MAXU
  } op_e;

  logic             r_s1_v;
  op_e              r_s1_op;
  logic [1:0]       r_s1_pack;
  logic [TAG_W-1:0] r_s1_tag;
  logic [XLEN-1:0]  r_s1_a;
  logic [XLEN-1:0]  r_s1_b;
  logic [XLEN-1:0]  r_s1_sum;
  logic [NB-1:0]    r_s1_co;
  logic [NB-1:0]    r_s1_cm;

  logic             r_s2_v;
  logic [XLEN-1:0]  r_y;
  logic [TAG_W-1:0] r_tag;
  logic             r_sat;
  logic             r_sticky;

  logic             w_sub;
  logic             w_s2_adv;
  logic             w_in_rdy;
  logic [XLEN-1:0]  w_sum;
  logic [NB-1:0]    w_co;
  logic [NB-1:0]    w_cm;
  logic [XLEN-1:0]  w_y;
  logic             w_sat;

  assign w_s2_adv   = !r_s2_v || out_ready;
  assign w_in_rdy   = !r_s1_v || w_s2_adv;
  assign in_ready   = w_in_rdy;
  assign out_valid  = r_s2_v;
  assign out_y      = r_y;
  assign out_tag    = r_tag;
  assign out_sat    = r_sat;
  assign sat_sticky = r_sticky;

  // compares and min/max all reuse the a-b subtractor
  assign w_sub = (in_op == 4'd1) || (in_op == 4'd3) ||
                 (in_op == 4'd5) || (in_op >= 4'd9);

  always_comb begin
    logic       cy;
    logic       st;
    logic [7:0] bx;
    logic [8:0] t;
    w_sum = '0;
    w_co  = '0;
    w_cm  = '0;
    cy    = 1'b0;
    st    = 1'b0;
    bx    = '0;
    t     = '0;
    for (int k = 0; k < NB; k++) begin
      unique case (in_pack)
        2'b10:   st = 1'b1;
        2'b00:   st = (k % 2 == 0);
        default: st = (k % 4 == 0);
      endcase
      if (st) cy = w_sub;
      bx = in_b[8*k +: 8] ^ {8{w_sub}};
      t  = {1'b0, in_a[8*k +: 8]} + {1'b0, bx} + {8'd0, cy};
      w_sum[8*k +: 8] = t[7:0];
      w_co[k] = t[8];
      w_cm[k] = in_a[8*k+7] ^ bx[7] ^ t[7];
      cy = t[8];
    end
  end

  // each byte looks up the flags of its lane's top byte
  always_comb begin
    logic       co, cm, sm, sg, top, eq;
    logic       ovf, lt, ltu, sat;
    logic [7:0] ab, bb, sb, yb;
    w_y   = '0;
    w_sat = 1'b0;
    co = 1'b0; cm = 1'b0; sm = 1'b0; sg = 1'b0;
    top = 1'b0; eq = 1'b0; ovf = 1'b0;
    lt = 1'b0; ltu = 1'b0; sat = 1'b0;
    ab = '0; bb = '0; sb = '0; yb = '0;
    for (int k = 0; k < NB; k++) begin
      unique case (r_s1_pack)
        2'b10: begin
          co  = r_s1_co[k];
          cm  = r_s1_cm[k];
          sm  = r_s1_sum[8*k+7];
          sg  = r_s1_a[8*k+7];
          top = 1'b1;
          eq  = (r_s1_sum[8*k +: 8] == '0);
        end
        2'b00: begin
          co  = r_s1_co[k|1];
          cm  = r_s1_cm[k|1];
          sm  = r_s1_sum[8*(k|1)+7];
          sg  = r_s1_a[8*(k|1)+7];
          top = (k % 2 == 1);
          eq  = (r_s1_sum[16*(k/2) +: 16] == '0);
        end
        default: begin
          co  = r_s1_co[k|3];
          cm  = r_s1_cm[k|3];
          sm  = r_s1_sum[8*(k|3)+7];
          sg  = r_s1_a[8*(k|3)+7];
          top = (k % 4 == 3);
          eq  = (r_s1_sum[32*(k/4) +: 32] == '0);
        end
      endcase
      ab  = r_s1_a[8*k +: 8];
      bb  = r_s1_b[8*k +: 8];
      sb  = r_s1_sum[8*k +: 8];
      ovf = cm ^ co;
      lt  = sm ^ ovf;
      ltu = !co;
      sat = 1'b0;
      yb  = sb;
      unique case (r_s1_op)
        OP_ADD, OP_SUB: yb = sb;
        OP_SADD, OP_SSUB: begin
          sat = ovf;
          if (ovf)
            yb = sg ? (top ? 8'h80 : 8'h00)
                    : (top ? 8'h7F : 8'hFF);
        end
        OP_UADD: begin
          sat = co;
          if (co) yb = 8'hFF;
        end
        OP_USUB: begin
          sat = !co;
          if (!co) yb = 8'h00;
        end
        OP_AND:  yb = ab & bb;
        OP_OR:   yb = ab | bb;
        OP_XOR:  yb = ab ^ bb;
        OP_SLT:  yb = {8{lt}};
        OP_SLTU: yb = {8{ltu}};
        OP_SEQ:  yb = {8{eq}};
        OP_MIN:  yb = lt  ? ab : bb;
        OP_MAX:  yb = lt  ? bb : ab;
        OP_MINU: yb = ltu ? ab : bb;
        OP_MAXU: yb = ltu ? bb : ab;
      endcase
      w_y[8*k +: 8] = yb;
      w_sat = w_sat | sat;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_rdy && in_valid) begin
      r_s1_op   <= op_e'(in_op);
      r_s1_pack <= in_pack;
      r_s1_tag  <= in_tag;
      r_s1_a    <= in_a;
      r_s1_b    <= in_b;
      r_s1_sum  <= w_sum;
      r_s1_co   <= w_co;
      r_s1_cm   <= w_cm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v   <= 1'b0;
      r_s2_v   <= 1'b0;
      r_y      <= '0;
      r_tag    <= '0;
      r_sat    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      if (flush) begin
        r_s1_v <= 1'b0;
        r_s2_v <= 1'b0;
      end else begin
        if (w_in_rdy) r_s1_v <= in_valid;
        if (w_s2_adv) r_s2_v <= r_s1_v;
      end
      if (w_s2_adv && r_s1_v) begin
        r_y   <= w_y;
        r_tag <= r_s1_tag;
        r_sat <= w_sat;
      end
      // a saturating transfer beats a same-cycle clear
      if (r_s2_v && out_ready && r_sat)
        r_sticky <= 1'b1;
      else if (sat_clr)
        r_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// tb_simd_alu_pipe: directed checks of simd_alu_pipe.
// Lane arithmetic, saturation, stalls, flush and reset.
module tb_simd_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [1:0]  in_pack;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [4:0]  out_tag;
  logic        out_sat;
  logic        sat_sticky;
  logic        sat_clr;

  int n_chk  = 0;
  int n_fail = 0;

  simd_alu_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_pack    (in_pack),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_tag    (out_tag),
    .out_sat    (out_sat),
    .sat_sticky (sat_sticky),
    .sat_clr    (sat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // issue one op with out_ready high; return first valid result
  task automatic run_op(input logic [3:0] op, input logic [1:0] pk,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg,
                        output logic [31:0] y, output logic s,
                        output logic [4:0] otg, output int lat);
    in_op = op; in_pack = pk; in_a = a; in_b = b; in_tag = tg;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    y = out_y; s = out_sat; otg = out_tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; sat_clr = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_pack = '0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_chk++; if (out_y !== 32'h0) begin n_fail++;
      $display("FAIL rst_out_y got %h want 0", out_y); end
    n_chk++; if (out_tag !== 5'h0) begin n_fail++;
      $display("FAIL rst_out_tag got %h want 0", out_tag); end
    n_chk++; if (out_sat !== 1'b0) begin n_fail++;
      $display("FAIL rst_out_sat got %b want 0", out_sat); end
    n_chk++; if (sat_sticky !== 1'b0) begin n_fail++;
      $display("FAIL rst_sticky got %b want 0", sat_sticky); end
    rst_n = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_sadd();
    logic [31:0] y; logic s; logic [4:0] t; int lat;
    run_op(4'd2, 2'b10, 32'h7F7F0180, 32'h0101FF80, 5'd9, y, s, t, lat);
    n_chk++; if (y !== 32'h7F7F0080) begin n_fail++;
      $display("FAIL sadd_y got %h want 7f7f0080", y); end
    n_chk++; if (s !== 1'b1) begin n_fail++;
      $display("FAIL sadd_sat got %b want 1", s); end
    n_chk++; if (lat !== 2) begin n_fail++;
      $display("FAIL sadd_latency got %0d want 2", lat); end
    n_chk++; if (t !== 5'd9) begin n_fail++;
      $display("FAIL sadd_tag got %0d want 9", t); end
    @(posedge clk); #1;
    n_chk++; if (sat_sticky !== 1'b1) begin n_fail++;
      $display("FAIL sadd_sticky got %b want 1", sat_sticky); end
  endtask

  task automatic test_add_lanes();
    logic [31:0] y; logic s; logic [4:0] t; int lat;
    run_op(4'd0, 2'b00, 32'h0001FFFF, 32'h00000001, 5'd1, y, s, t, lat);
    n_chk++; if (y !== 32'h00010000) begin n_fail++;
      $display("FAIL add_half got %h want 00010000", y); end
    @(posedge clk); #1;
    run_op(4'd0, 2'b11, 32'h0001FFFF, 32'h00000001, 5'd2, y, s, t, lat);
    n_chk++; if (y !== 32'h00020000) begin n_fail++;
      $display("FAIL add_word got %h want 00020000", y); end
    @(posedge clk); #1;
    run_op(4'd0, 2'b01, 32'h0001FFFF, 32'h00000001, 5'd3, y, s, t, lat);
    n_chk++; if (y !== 32'h00020000) begin n_fail++;
      $display("FAIL add_pack01 got %h want 00020000", y); end
    @(posedge clk); #1;
  endtask

  task automatic test_usub_clr();
    logic [31:0] y; logic s; logic [4:0] t; int lat;
    run_op(4'd5, 2'b10, 32'h10203040, 32'h20202020, 5'd4, y, s, t, lat);
    n_chk++; if (y !== 32'h00001020) begin n_fail++;
      $display("FAIL usub_y got %h want 00001020", y); end
    n_chk++; if (s !== 1'b1) begin n_fail++;
      $display("FAIL usub_sat got %b want 1", s); end
    @(posedge clk); #1;
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    n_chk++; if (sat_sticky !== 1'b0) begin n_fail++;
      $display("FAIL clr_sticky got %b want 0", sat_sticky); end
  endtask

  task automatic test_uadd_setwins();
    logic [31:0] y; logic s; logic [4:0] t; int lat;
    run_op(4'd4, 2'b10, 32'hFF010203, 32'h01010101, 5'd5, y, s, t, lat);
    n_chk++; if (y !== 32'hFF020304) begin n_fail++;
      $display("FAIL uadd_y got %h want ff020304", y); end
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    n_chk++; if (sat_sticky !== 1'b1) begin n_fail++;
      $display("FAIL setwins_sticky got %b want 1", sat_sticky); end
  endtask

  task automatic test_compare_minmax();
    logic [31:0] y; logic s; logic [4:0] t; int lat;
    run_op(4'd9, 2'b00, 32'h80000003, 32'h00000002, 5'd6, y, s, t, lat);
    n_chk++; if (y !== 32'hFFFF0000) begin n_fail++;
      $display("FAIL slt_half got %h want ffff0000", y); end
    @(posedge clk); #1;
    run_op(4'd14, 2'b11, 32'hFFFFFFFF, 32'h00000001, 5'd7, y, s, t, lat);
    n_chk++; if (y !== 32'h00000001) begin n_fail++;
      $display("FAIL minu_y got %h want 00000001", y); end
    n_chk++; if (s !== 1'b0) begin n_fail++;
      $display("FAIL minu_sat got %b want 0", s); end
    @(posedge clk); #1;
    run_op(4'd13, 2'b00, 32'h7FFF8000, 32'h80000001, 5'd8, y, s, t, lat);
    n_chk++; if (y !== 32'h7FFF0001) begin n_fail++;
      $display("FAIL max_half got %h want 7fff0001", y); end
    @(posedge clk); #1;
    run_op(4'd11, 2'b10, 32'h12345678, 32'h12005678, 5'd10, y, s, t, lat);
    n_chk++; if (y !== 32'hFF00FFFF) begin n_fail++;
      $display("FAIL seq_byte got %h want ff00ffff", y); end
    @(posedge clk); #1;
    run_op(4'd3, 2'b11, 32'h80000000, 32'h00000001, 5'd11, y, s, t, lat);
    n_chk++; if (y !== 32'h80000000) begin n_fail++;
      $display("FAIL ssub_word got %h want 80000000", y); end
    n_chk++; if (s !== 1'b1) begin n_fail++;
      $display("FAIL ssub_sat got %b want 1", s); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_op = 4'd0; in_pack = 2'b11; in_b = 32'h0;
    in_valid = 1'b1; in_a = 32'd1; in_tag = 5'd1;
    @(posedge clk); #1;
    in_a = 32'd2; in_tag = 5'd2;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL b2b_ready2 got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_a = 32'd3; in_tag = 5'd3;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (in_ready !== 1'b0) begin n_fail++;
        $display("FAIL b2b_stall_ready got %b want 0", in_ready); end
      n_chk++; if (out_valid !== 1'b1 || out_tag !== 5'd1 ||
                   out_y !== 32'd1) begin n_fail++;
        $display("FAIL b2b_hold got v=%b tag=%0d y=%h want 1 1 1",
                 out_valid, out_tag, out_y); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || out_tag !== 5'd2) begin n_fail++;
      $display("FAIL b2b_second got v=%b tag=%0d want 1 2",
               out_valid, out_tag); end
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 1'b1 || out_tag !== 5'd3 ||
                 out_y !== 32'd3) begin n_fail++;
      $display("FAIL b2b_third got v=%b tag=%0d y=%h want 1 3 3",
               out_valid, out_tag, out_y); end
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic fill_two();
    out_ready = 1'b0;
    in_op = 4'd0; in_pack = 2'b11; in_b = 32'h0;
    in_valid = 1'b1; in_a = 32'd20; in_tag = 5'd20;
    @(posedge clk); #1;
    in_a = 32'd21; in_tag = 5'd21;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] y; logic s; logic [4:0] t; int lat; int seen;
    fill_two();
    in_valid = 1'b1; in_tag = 5'd22; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_valid got %b want 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL flush_ready got %b want 1", in_ready); end
    n_chk++; if (sat_sticky !== 1'b1) begin n_fail++;
      $display("FAIL flush_sticky got %b want 1", sat_sticky); end
    out_ready = 1'b1;
    in_valid = 1'b1; in_tag = 5'd23; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (4) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_chk++; if (seen !== 0) begin n_fail++;
      $display("FAIL flush_ghost got %0d results want 0", seen); end
    run_op(4'd8, 2'b11, 32'hF0F0F0F0, 32'hFF00FF00, 5'd24, y, s, t, lat);
    n_chk++; if (y !== 32'h0FF00FF0 || t !== 5'd24) begin n_fail++;
      $display("FAIL flush_next got y=%h tag=%0d want 0ff00ff0 24", y, t); end
    n_chk++; if (lat !== 2) begin n_fail++;
      $display("FAIL flush_latency got %0d want 2", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] y; logic s; logic [4:0] t; int lat; int seen;
    fill_two();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_valid got %b want 0", out_valid); end
    n_chk++; if (sat_sticky !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_sticky got %b want 0", sat_sticky); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_chk++; if (seen !== 0) begin n_fail++;
      $display("FAIL rstmid_ghost got %0d results want 0", seen); end
    run_op(4'd6, 2'b11, 32'hF0F0F0F0, 32'hFF00FF00, 5'd25, y, s, t, lat);
    n_chk++; if (y !== 32'hF000F000 || lat !== 2) begin n_fail++;
      $display("FAIL rstmid_next got y=%h lat=%0d want f000f000 2", y, lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_sadd();
    test_add_lanes();
    test_usub_clr();
    test_uadd_setwins();
    test_compare_minmax();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
